// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its requesters.
package mem_port_arbiter_pkg;

  localparam int ACCESS_ID_WIDTH  = 7;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 64;
  localparam int CORE_ID_W        = 4;
  localparam int TAG_W            = 2;
  localparam int BEAT_BYTES       = DATA_W / 8;
  localparam int CACHE_BLOCK_SIZE = 256;  // bytes per line
  localparam int MAX_BURST        = CACHE_BLOCK_SIZE / BEAT_BYTES;
  localparam int LEN_W            = $clog2(MAX_BURST) + 1;

  // ID tags carried in the top bits of access_id, one per requester.
  localparam logic [TAG_W-1:0] TAG_ICACHE = 2'b01;
  localparam logic [TAG_W-1:0] TAG_DCACHE = 2'b10;
  localparam logic [TAG_W-1:0] TAG_VLSU   = 2'b11;

  typedef enum logic [2:0] {
    READ_REQ,
    READ_RSP,
    WRITE_REQ,
    WRITE_RSP
  } access_t;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  typedef struct packed {
    logic                       vld;
    access_t                    access_type;
    logic [ACCESS_ID_WIDTH-1:0] access_id;
    logic [CORE_ID_W-1:0]       core_id;
    logic [ADDR_W-1:0]          addr;
    logic [DATA_W-1:0]          data;
    logic [LEN_W-1:0]           access_length;
  } request_t;

  // A zero length is a single beat.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  function automatic logic [TAG_W-1:0] id_tag(input request_t r);
    return r.access_id[ACCESS_ID_WIDTH-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first set bit of vld at or after ptr (cyclic), one-hot.
module rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     vld,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  // Scan from the farthest position back to ptr so the nearest valid wins.
  always_comb begin
    // NOTE: default assigned before the loop so every path drives pick (no latch).
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vld[(int'(ptr) + k) % N]) pick = N'(1) << ((int'(ptr) + k) % N);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst-locked round-robin arbiter for the shared memory request port,
// plus ID-tag based routing of memory responses back to the requesters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                   N_REQ   = 3,
  parameter logic [CORE_ID_W-1:0] CORE_ID = '0,
  parameter logic [TAG_W-1:0]     ID_TAG [N_REQ] = '{TAG_ICACHE, TAG_DCACHE, TAG_VLSU}
) (
  input  logic             clk,
  input  logic             reset,
  input  request_t         req [N_REQ],
  output logic [N_REQ-1:0] req_grant,
  output request_t         rsp [N_REQ],
  output request_t         mem_req,
  input  logic             mem_grant,
  input  request_t         mem_rsp,
  output logic             unmapped_rsp
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [LEN_W-1:0] burst_len, burst_len_nxt;
  request_t         mem_req_nxt;
  logic [N_REQ-1:0] vld_vec, pick, rsp_hit;
  logic [PTR_W-1:0] pick_idx;
  logic [LEN_W-1:0] pick_len;
  logic             slot_free;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
    .vld  (vld_vec),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  // Request valid vector, picked index, and response tag matches.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      vld_vec[i] = req[i].vld;
      rsp_hit[i] = mem_rsp.vld && (id_tag(mem_rsp) == ID_TAG[i]);
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  // The slot is free when memory holds nothing or takes what it holds now.
  assign slot_free = !mem_req.vld || mem_grant;
  assign pick_len  = eff_len(req[pick_idx].access_length);

  // Arbitration FSM: grant, next mem_req, pointer and burst bookkeeping.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    beat_cnt_nxt  = beat_cnt;
    burst_len_nxt = burst_len;
    mem_req_nxt   = mem_req;
    req_grant     = '0;
    if (mem_grant) mem_req_nxt.vld = 1'b0;
    unique case (state)
      IDLE: begin
        if (reset && slot_free && (|pick)) begin
          req_grant           = pick;
          mem_req_nxt         = req[pick_idx];
          mem_req_nxt.core_id = CORE_ID;
          if (pick_len > LEN_W'(1)) begin
            owner_nxt     = pick_idx;
            beat_cnt_nxt  = LEN_W'(1);
            burst_len_nxt = pick_len;
            state_nxt     = BURST;
          end else begin
            rr_ptr_nxt = inc_ptr(pick_idx);
          end
        end
      end
      BURST: begin
        if (reset && slot_free && req[owner].vld) begin
          req_grant[owner]    = 1'b1;
          mem_req_nxt         = req[owner];
          mem_req_nxt.core_id = CORE_ID;
          beat_cnt_nxt        = beat_cnt + LEN_W'(1);
          if (beat_cnt_nxt == burst_len) begin
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = inc_ptr(owner);
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state and the registered memory request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      burst_len <= '0;
      mem_req   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      beat_cnt  <= beat_cnt_nxt;
      burst_len <= burst_len_nxt;
      mem_req   <= mem_req_nxt;
    end
  end

  // Response demux: forward to the tag owner, flag tags nobody owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: a small register bank, not a RAM, so it is cleared on reset.
      for (int i = 0; i < N_REQ; i++) rsp[i] <= '0;
      unmapped_rsp <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_hit[i]) rsp[i] <= mem_rsp;
        else            rsp[i].vld <= 1'b0;
      end
      unmapped_rsp <= mem_rsp.vld && !(|rsp_hit);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N = 3;
  localparam logic [CORE_ID_W-1:0] CORE = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  request_t   req [N];
  logic [N-1:0] req_grant;
  request_t   rsp [N];
  request_t   mem_req;
  logic       mem_grant;
  request_t   mem_rsp;
  logic       unmapped_rsp;

  logic [1:0] tag_of [N] = '{2'b01, 2'b10, 2'b11};

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int       m_ptr, m_owner, m_left;
  request_t exp_mem_req;
  request_t exp_rsp [N];
  logic     exp_unm;
  int       grant_log[$];
  int       last_obs;

  mem_port_arbiter #(.N_REQ(N), .CORE_ID(CORE)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_grant    (req_grant),
    .rsp          (rsp),
    .mem_req      (mem_req),
    .mem_grant    (mem_grant),
    .mem_rsp      (mem_rsp),
    .unmapped_rsp (unmapped_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic request_t make_req(input int i, input logic [ADDR_W-1:0] addr, input int len);
    request_t r;
    r               = '0;
    r.vld           = 1'b1;
    r.access_type   = access_t'(3'($urandom_range(0, 3)));
    r.access_id     = {tag_of[i], 5'($urandom)};
    r.core_id       = 4'($urandom);
    r.addr          = addr;
    r.data          = {$urandom, $urandom};
    r.access_length = LEN_W'(len);
    return r;
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_owner     = -1;
    m_left      = 0;
    exp_mem_req = '0;
    for (int i = 0; i < N; i++) exp_rsp[i] = '0;
    exp_unm  = 1'b0;
    last_obs = -1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) req[i] = '0;
    mem_rsp   = '0;
    mem_grant = 1'b1;
  endtask

  // One clock of stimulus: check the same-cycle grant, advance the model,
  // then check registered outputs just after the edge. Starts and ends at negedge.
  task automatic cycle();
    int g;
    int hit;
    int len;
    logic [N-1:0] exp_g;
    #1;
    g = -1;
    if (reset && (!exp_mem_req.vld || mem_grant)) begin
      if (m_owner >= 0) begin
        if (req[m_owner].vld) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_ptr + k) % N].vld) g = (m_ptr + k) % N;
      end
    end
    exp_g = (g >= 0) ? (3'b001 << g) : 3'b000;
    checks++;
    if (req_grant !== exp_g) begin
      errors++;
      $display("FAIL req_grant at %0t: got %b expected %b", $time, req_grant, exp_g);
    end
    last_obs = -1;
    for (int i = 0; i < N; i++)
      if (req_grant[i]) last_obs = (last_obs < 0) ? i : 99;
    grant_log.push_back(last_obs);

    if (g >= 0) begin
      exp_mem_req         = req[g];
      exp_mem_req.core_id = CORE;
      if (m_owner < 0) begin
        len = (req[g].access_length == 0) ? 1 : int'(req[g].access_length);
        if (len > 1) begin
          m_owner = g;
          m_left  = len - 1;
        end else begin
          m_ptr = (g + 1) % N;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (mem_grant) begin
      exp_mem_req.vld = 1'b0;
    end

    hit = -1;
    for (int i = 0; i < N; i++)
      if (mem_rsp.access_id[ACCESS_ID_WIDTH-1 -: 2] == tag_of[i]) hit = i;
    for (int i = 0; i < N; i++) begin
      if (mem_rsp.vld && hit == i) exp_rsp[i] = mem_rsp;
      else exp_rsp[i].vld = 1'b0;
    end
    exp_unm = mem_rsp.vld && (hit < 0);

    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== exp_mem_req) begin
      errors++;
      $display("FAIL mem_req at %0t: got %h expected %h", $time, mem_req, exp_mem_req);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rsp[i].vld !== exp_rsp[i].vld || (exp_rsp[i].vld && rsp[i] !== exp_rsp[i])) begin
        errors++;
        $display("FAIL rsp[%0d] at %0t: got %h expected %h", i, $time, rsp[i], exp_rsp[i]);
      end
    end
    checks++;
    if (unmapped_rsp !== exp_unm) begin
      errors++;
      $display("FAIL unmapped_rsp at %0t: got %b expected %b", $time, unmapped_rsp, exp_unm);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (req_grant !== '0 || mem_req !== '0 || unmapped_rsp !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got grant=%b mem_req=%h unmapped=%b expected all 0",
               tag, req_grant, mem_req, unmapped_rsp);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rsp[i] !== '0) begin
        errors++;
        $display("FAIL %s rsp[%0d]: got %h expected 0", tag, i, rsp[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    req[0] = make_req(0, 32'h10, 1);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    req[0] = '0;
    reset  = 1'b1;
  endtask

  task automatic test_single();
    idle_inputs();
    req[1] = make_req(1, 32'h40, 1);
    cycle();
    checks++;
    if (grant_log[$] !== 1) begin
      errors++;
      $display("FAIL single_grant: got %0d expected 1", grant_log[$]);
    end
    checks++;
    if (mem_req.vld !== 1'b1 || mem_req.addr !== 32'h40 || mem_req.core_id !== CORE) begin
      errors++;
      $display("FAIL single_mem_req: got vld=%b addr=%h core=%h expected 1/00000040/%h",
               mem_req.vld, mem_req.addr, mem_req.core_id, CORE);
    end
    for (int i = 0; i < N; i++) req[i] = make_req(i, 32'h100 + 32'(i), 1);
    cycle();
    checks++;
    if (grant_log[$] !== 2) begin
      errors++;
      $display("FAIL single_rr_ptr: got %0d expected 2", grant_log[$]);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_burst_lock();
    int bad;
    idle_inputs();
    req[0] = make_req(0, 32'h1000, 32);
    req[2] = make_req(2, 32'h2000, 1);
    grant_log.delete();
    for (int c = 0; c < 33; c++) begin
      cycle();
      if (last_obs == 0) req[0].addr = req[0].addr + 32'd8;
    end
    bad = 0;
    for (int c = 0; c < 32; c++) if (grant_log[c] != 0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL burst_lock: %0d of first 32 grants not to 0, expected 0", bad);
    end
    checks++;
    if (grant_log[32] !== 2) begin
      errors++;
      $display("FAIL burst_release: got %0d expected 2", grant_log[32]);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    idle_inputs();
    for (int i = 0; i < N; i++) req[i] = make_req(i, 32'h300 + 32'(i), 1);
    grant_log.delete();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (last_obs >= 0 && last_obs < N) req[last_obs] = make_req(last_obs, 32'($urandom), 1);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (grant_log[c] !== exp_order[c]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", c, grant_log[c], exp_order[c]);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_backpressure();
    request_t r1, exp_hold;
    idle_inputs();
    r1     = make_req(1, 32'h80, 1);
    req[1] = r1;
    cycle();
    exp_hold         = r1;
    exp_hold.core_id = CORE;
    req[1]    = make_req(1, 32'h84, 1);
    mem_grant = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (grant_log[$] !== -1 || mem_req !== exp_hold) begin
        errors++;
        $display("FAIL backpressure[%0d]: got grant=%0d mem_req=%h expected none/%h",
                 c, grant_log[$], mem_req, exp_hold);
      end
    end
    mem_grant = 1'b1;
    cycle();
    checks++;
    if (grant_log[$] !== 1) begin
      errors++;
      $display("FAIL backpressure_resume: got %0d expected 1", grant_log[$]);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_rsp_routing();
    idle_inputs();
    mem_rsp             = '0;
    mem_rsp.vld         = 1'b1;
    mem_rsp.access_type = READ_RSP;
    mem_rsp.access_id   = 7'b1000011;
    mem_rsp.data        = 64'hDEAD_BEEF_0123_4567;
    req[2]              = make_req(2, 32'h500, 1);
    cycle();
    checks++;
    if (rsp[1].vld !== 1'b1 || rsp[1].data !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL route_rsp1: got vld=%b data=%h expected 1/deadbeef01234567",
               rsp[1].vld, rsp[1].data);
    end
    checks++;
    if (rsp[0].vld !== 1'b0 || rsp[2].vld !== 1'b0 || grant_log[$] !== 2) begin
      errors++;
      $display("FAIL route_others: got rsp0=%b rsp2=%b grant=%0d expected 0/0/2",
               rsp[0].vld, rsp[2].vld, grant_log[$]);
    end
    req[2]            = '0;
    mem_rsp.access_id = 7'b0010101;
    cycle();
    checks++;
    if (unmapped_rsp !== 1'b1 || {rsp[0].vld, rsp[1].vld, rsp[2].vld} !== 3'b000) begin
      errors++;
      $display("FAIL unmapped: got flag=%b rsp_vld=%b%b%b expected 1/000",
               unmapped_rsp, rsp[0].vld, rsp[1].vld, rsp[2].vld);
    end
    mem_rsp = '0;
    cycle();
    checks++;
    if (unmapped_rsp !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_pulse: got %b expected 0", unmapped_rsp);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n0;
    idle_inputs();
    req[0] = make_req(0, 32'h3000, 32);
    grant_log.delete();
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (last_obs == 0) req[0].addr = req[0].addr + 32'd8;
    end
    n0 = 0;
    foreach (grant_log[c]) if (grant_log[c] == 0) n0++;
    checks++;
    if (n0 != 10) begin
      errors++;
      $display("FAIL pre_reset_beats: got %0d expected 10", n0);
    end
    reset = 1'b0;
    #1;
    check_all_zero("mid_burst_reset");
    @(posedge clk);
    #1;
    check_all_zero("mid_burst_hold");
    @(negedge clk);
    model_reset();
    req[0] = '0;
    reset  = 1'b1;
    req[2] = make_req(2, 32'h600, 1);
    cycle();
    checks++;
    if (grant_log[$] !== 2 || mem_req.addr !== 32'h600) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%0d addr=%h expected 2/00000600",
               grant_log[$], mem_req.addr);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i].vld || last_obs == i) begin
          if ($urandom_range(0, 99) < 55) req[i] = make_req(i, 32'($urandom), $urandom_range(0, 4));
          else req[i] = '0;
        end
      end
      mem_grant = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        mem_rsp             = '0;
        mem_rsp.vld         = 1'b1;
        mem_rsp.access_type = READ_RSP;
        mem_rsp.access_id   = 7'($urandom);
        mem_rsp.addr        = 32'($urandom);
        mem_rsp.data        = {$urandom, $urandom};
      end else begin
        mem_rsp = '0;
      end
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_lock();
    test_round_robin();
    test_backpressure();
    test_rsp_routing();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
